// File: rtl/adpll_mon_pkg.sv
// Shared types and helpers for the ADPLL lock monitor: FSM states, default counter
// width and the expected OUT_CLK/REF_CLK ratio for a multiplier select.
package adpll_mon_pkg;

    localparam int CNT_W_DEF = 8;

    typedef enum logic [1:0] {
        WAIT_EDGE = 2'd0,
        COUNT     = 2'd1,
        LOCKED    = 2'd2
    } mon_state_e;

    // m = 0..7 selects a ratio of 2..16 OUT_CLK periods per REF_CLK period
    function automatic logic [4:0] exp_ratio(input logic [2:0] m);
        logic [4:0] r;
        r = {2'b00, m} + 5'd1;
        return r << 1;
    endfunction

endpackage

// File: rtl/adpll_mon_sync.sv
// Multi-flop synchronizer bringing an asynchronous level into the OUT_CLK domain.
module adpll_mon_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_reg <= '0;
        end else begin
            sync_reg <= {sync_reg[STAGES-2:0], d};
        end
    end

    assign q = sync_reg[STAGES-1];

endmodule

// File: rtl/adpll_lock_monitor.sv
// Independent frequency-lock checker for the ADPLL output clock; counts OUT_CLK cycles
// per REF_CLK period. Define ADPLL_MON_HIST_EN to add MIN_CNT/MAX_CNT history outputs.
module adpll_lock_monitor
    import adpll_mon_pkg::*;
#(
    parameter int CNT_W       = CNT_W_DEF,
    parameter int SYNC_STAGES = 2,
    parameter int TOL         = 1,
    parameter int LOCK_CYCLES = 4
) (
    input  logic             OUT_CLK,
    input  logic             RESET,
    input  logic             REF_CLK,
    input  logic             M2,
    input  logic             M1,
    input  logic             M0,
    input  logic             LOCK,
    output logic [CNT_W-1:0] MEAS_CNT,
    output logic             MEAS_VALID,
    output logic             FREQ_OK,
    output logic             LOCK_ERR
`ifdef ADPLL_MON_HIST_EN
    ,
    output logic [CNT_W-1:0] MIN_CNT,
    output logic [CNT_W-1:0] MAX_CNT
`endif
);

    localparam logic [3:0] LOCK_N = 4'(LOCK_CYCLES);

    logic             ref_s;
    logic             lock_s;
    logic             ref_prev_reg;
    logic             ref_rise;
    logic [2:0]       m_now;
    logic [2:0]       m_reg;
    logic             m_change;
    logic [CNT_W-1:0] cnt_reg;
    logic             cnt_sat;
    mon_state_e       state_reg;
    logic [3:0]       mcnt_reg;
    logic [3:0]       mcnt_next;
    logic             match;
    int               diff;
    logic             measure;
    logic [CNT_W-1:0] meas_cnt_reg;
    logic             meas_valid_reg;
    logic             freq_ok_reg;
    logic             lock_err_reg;
`ifdef ADPLL_MON_HIST_EN
    logic [CNT_W-1:0] min_cnt_reg;
    logic [CNT_W-1:0] max_cnt_reg;
`endif

    adpll_mon_sync #(.STAGES(SYNC_STAGES)) u_ref_sync (
        .clk (OUT_CLK),
        .rst (RESET),
        .d   (REF_CLK),
        .q   (ref_s)
    );

    adpll_mon_sync #(.STAGES(SYNC_STAGES)) u_lock_sync (
        .clk (OUT_CLK),
        .rst (RESET),
        .d   (LOCK),
        .q   (lock_s)
    );

    assign ref_rise = ref_s & ~ref_prev_reg;
    assign m_now    = {M2, M1, M0};
    assign m_change = (m_now != m_reg);
    assign cnt_sat  = &cnt_reg;
    // A measurement in the same cycle as a multiplier change belongs to the old ratio
    assign measure  = ref_rise && !m_change && (state_reg != WAIT_EDGE);

    always_comb begin
        diff = int'(cnt_reg) - int'(exp_ratio(m_reg));
        if (diff < 0) begin
            diff = -diff;
        end
        match     = (diff <= TOL) && !cnt_sat;
        mcnt_next = (mcnt_reg >= LOCK_N) ? LOCK_N : mcnt_reg + 4'd1;
    end

    always_ff @(posedge OUT_CLK or posedge RESET) begin
        if (RESET) begin
            ref_prev_reg   <= 1'b0;
            m_reg          <= '0;
            cnt_reg        <= '0;
            state_reg      <= WAIT_EDGE;
            mcnt_reg       <= '0;
            meas_cnt_reg   <= '0;
            meas_valid_reg <= 1'b0;
            freq_ok_reg    <= 1'b0;
            lock_err_reg   <= 1'b0;
`ifdef ADPLL_MON_HIST_EN
            min_cnt_reg    <= '1;
            max_cnt_reg    <= '0;
`endif
        end else begin
            ref_prev_reg   <= ref_s;
            m_reg          <= m_now;
            meas_valid_reg <= measure;
            if (ref_rise) begin
                cnt_reg <= CNT_W'(1);
            end else if (!cnt_sat) begin
                cnt_reg <= cnt_reg + CNT_W'(1);
            end

            if (m_change) begin
                state_reg   <= WAIT_EDGE;
                mcnt_reg    <= '0;
                freq_ok_reg <= 1'b0;
`ifdef ADPLL_MON_HIST_EN
                min_cnt_reg <= '1;
                max_cnt_reg <= '0;
`endif
            end else if (ref_rise) begin
                if (state_reg == WAIT_EDGE) begin
                    state_reg <= COUNT;
                end else begin
                    meas_cnt_reg <= cnt_reg;
`ifdef ADPLL_MON_HIST_EN
                    if (cnt_reg < min_cnt_reg) min_cnt_reg <= cnt_reg;
                    if (cnt_reg > max_cnt_reg) max_cnt_reg <= cnt_reg;
`endif
                    if (match) begin
                        mcnt_reg <= mcnt_next;
                        if (mcnt_next == LOCK_N) begin
                            state_reg   <= LOCKED;
                            freq_ok_reg <= 1'b1;
                        end
                    end else begin
                        mcnt_reg    <= '0;
                        freq_ok_reg <= 1'b0;
                        state_reg   <= COUNT;
                        if (lock_s) lock_err_reg <= 1'b1;
                    end
                end
            end
        end
    end

    assign MEAS_CNT   = meas_cnt_reg;
    assign MEAS_VALID = meas_valid_reg;
    assign FREQ_OK    = freq_ok_reg;
    assign LOCK_ERR   = lock_err_reg;
`ifdef ADPLL_MON_HIST_EN
    assign MIN_CNT    = min_cnt_reg;
    assign MAX_CNT    = max_cnt_reg;
`endif

endmodule

// File: tb/tb_adpll_lock_monitor.sv
// Self-checking bench for adpll_lock_monitor: directed scenarios plus a randomized
// REF_CLK period stream, checked against an edge-level behavioural model.
module tb_adpll_lock_monitor;

    logic       OUT_CLK = 1'b0;
    logic       RESET   = 1'b1;
    logic       REF_CLK = 1'b0;
    logic       M2 = 1'b0, M1 = 1'b1, M0 = 1'b1;
    logic       LOCK    = 1'b0;
    logic [7:0] MEAS_CNT;
    logic       MEAS_VALID;
    logic       FREQ_OK;
    logic       LOCK_ERR;
`ifdef ADPLL_MON_HIST_EN
    logic [7:0] MIN_CNT;
    logic [7:0] MAX_CNT;
`endif

    adpll_lock_monitor dut (
        .OUT_CLK    (OUT_CLK),
        .RESET      (RESET),
        .REF_CLK    (REF_CLK),
        .M2         (M2),
        .M1         (M1),
        .M0         (M0),
        .LOCK       (LOCK),
        .MEAS_CNT   (MEAS_CNT),
        .MEAS_VALID (MEAS_VALID),
        .FREQ_OK    (FREQ_OK),
        .LOCK_ERR   (LOCK_ERR)
`ifdef ADPLL_MON_HIST_EN
        ,
        .MIN_CNT    (MIN_CNT),
        .MAX_CNT    (MAX_CNT)
`endif
    );

    always #5 OUT_CLK = ~OUT_CLK;

    typedef struct packed {
        logic [7:0] cnt;
        logic       fok;
        logic       lerr;
    } meas_t;

    meas_t obs_q[$];
    meas_t exp_q[$];

    int pass_cnt  = 0;
    int total_cnt = 0;

    // model state: measurements are decided at each REF_CLK rising edge
    int   since     = 0;
    bit   mdl_armed = 0;
    int   mdl_mcnt  = 0;
    logic mdl_fok   = 1'b0;
    logic mdl_lerr  = 1'b0;
    int   mdl_min   = 255;
    int   mdl_max   = 0;

    always @(posedge OUT_CLK) begin
        #2;
        if (MEAS_VALID === 1'b1) begin
            obs_q.push_back('{cnt: MEAS_CNT, fok: FREQ_OK, lerr: LOCK_ERR});
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total_cnt++;
        assert (obs === expv) pass_cnt++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    endtask

    task automatic model_edge();
        int p, e, d;
        meas_t x;
        if (!mdl_armed) begin
            mdl_armed = 1;
            return;
        end
        p = (since > 255) ? 255 : since;
        e = 2 * (int'({M2, M1, M0}) + 1);
        d = p - e;
        if (d < 0) d = -d;
        if (d <= 1 && p != 255) begin
            if (mdl_mcnt < 4) mdl_mcnt++;
            if (mdl_mcnt == 4) mdl_fok = 1'b1;
        end else begin
            mdl_mcnt = 0;
            mdl_fok  = 1'b0;
            if (LOCK) mdl_lerr = 1'b1;
        end
        if (p < mdl_min) mdl_min = p;
        if (p > mdl_max) mdl_max = p;
        x.cnt  = 8'(p);
        x.fok  = mdl_fok;
        x.lerr = mdl_lerr;
        exp_q.push_back(x);
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) begin
            REF_CLK = 1'b0;
            @(posedge OUT_CLK);
            #1;
            since++;
        end
    endtask

    // one REF_CLK period of n OUT_CLK cycles, starting with a rising edge
    task automatic ref_cycle(input int n);
        model_edge();
        since = 0;
        for (int i = 0; i < n; i++) begin
            REF_CLK = (i < n / 2);
            @(posedge OUT_CLK);
            #1;
            since++;
        end
    endtask

    task automatic set_m(input logic [2:0] v);
        if (v != {M2, M1, M0}) begin
            mdl_armed = 0;
            mdl_mcnt  = 0;
            mdl_fok   = 1'b0;
            mdl_min   = 255;
            mdl_max   = 0;
        end
        {M2, M1, M0} = v;
        @(posedge OUT_CLK);
        #1;
        since++;
        chk("freq_ok_after_m", FREQ_OK, mdl_fok);
    endtask

    task automatic do_reset();
        @(posedge OUT_CLK);
        #1;
        REF_CLK = 1'b0;
        RESET   = 1'b1;
        #3;
        chk("rst_meas_cnt", MEAS_CNT, 0);
        chk("rst_meas_valid", MEAS_VALID, 0);
        chk("rst_freq_ok", FREQ_OK, 0);
        chk("rst_lock_err", LOCK_ERR, 0);
`ifdef ADPLL_MON_HIST_EN
        chk("rst_min_cnt", MIN_CNT, 255);
        chk("rst_max_cnt", MAX_CNT, 0);
`endif
        @(posedge OUT_CLK);
        #1;
        RESET = 1'b0;
        obs_q.delete();
        exp_q.delete();
        mdl_armed = 0;
        mdl_mcnt  = 0;
        mdl_fok   = 1'b0;
        mdl_lerr  = 1'b0;
        mdl_min   = 255;
        mdl_max   = 0;
        since     = 0;
        idle(3);
    endtask

    task automatic check_meas(input string tag);
        meas_t o, e;
        chk({tag, "_num_meas"}, obs_q.size(), exp_q.size());
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            chk({tag, "_meas_cnt"}, o.cnt, e.cnt);
            chk({tag, "_freq_ok"}, o.fok, e.fok);
            chk({tag, "_lock_err"}, o.lerr, e.lerr);
        end
        obs_q.delete();
        exp_q.delete();
        chk({tag, "_freq_ok_level"}, FREQ_OK, mdl_fok);
        chk({tag, "_lock_err_level"}, LOCK_ERR, mdl_lerr);
    endtask

    initial begin
        int e, n;
        do_reset();

        // steady 8-cycle periods at m=3
        for (int i = 0; i < 7; i++) ref_cycle(8);
        check_meas("t1");
        chk("t1_locked", FREQ_OK, 1);

        // one stretched period drops lock, four good ones restore it
        ref_cycle(11);
        for (int i = 0; i < 5; i++) ref_cycle(8);
        check_meas("t2");

        // periods within tolerance still lock
        do_reset();
        ref_cycle(9); ref_cycle(7); ref_cycle(9); ref_cycle(7); ref_cycle(9); ref_cycle(8);
        check_meas("t3");
        chk("t3_locked", FREQ_OK, 1);

        // false lock claim latches LOCK_ERR until reset
        LOCK = 1'b1;
        do_reset();
        for (int i = 0; i < 3; i++) ref_cycle(12);
        check_meas("t4a");
        LOCK = 1'b0;
        for (int i = 0; i < 6; i++) ref_cycle(8);
        check_meas("t4b");
        chk("t4_sticky", LOCK_ERR, 1);
        do_reset();

        // multiplier change while locked
        for (int i = 0; i < 6; i++) ref_cycle(8);
        ref_cycle(8);
        set_m(3'd5);
        idle(4);
        for (int i = 0; i < 5; i++) ref_cycle(12);
        check_meas("t5");
        chk("t5_relocked", FREQ_OK, 1);

        // REF_CLK stop saturates the counter, then reset mid-count
        set_m(3'd3);
        idle(2);
        for (int i = 0; i < 7; i++) ref_cycle(8);
        idle(300);
        chk("t6_hold_freq_ok", FREQ_OK, 1);
        LOCK = 1'b1;
        ref_cycle(8);
        check_meas("t6");
`ifdef ADPLL_MON_HIST_EN
        chk("t6_min_cnt", MIN_CNT, mdl_min);
        chk("t6_max_cnt", MAX_CNT, mdl_max);
`endif
        idle(20);
        LOCK = 1'b0;
        do_reset();

        // randomized period stream with occasional m and LOCK changes
        for (int it = 0; it < 60; it++) begin
            e = 2 * (int'({M2, M1, M0}) + 1);
            n = e - 2 + int'($urandom_range(4));
            if ($urandom_range(9) == 0) n = 3 + int'($urandom_range(30));
            if (n < 3) n = 3;
            ref_cycle(n);
            if ($urandom_range(7) == 0) begin
                idle(6);
                LOCK = 1'($urandom_range(1));
                set_m(3'($urandom_range(7)));
                idle(2);
            end
        end
        idle(8);
        check_meas("rnd");
`ifdef ADPLL_MON_HIST_EN
        chk("rnd_min_cnt", MIN_CNT, mdl_min);
        chk("rnd_max_cnt", MAX_CNT, mdl_max);
`endif

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
